// File: rtl/serial_neg_deserializer.sv
// Serial two's-complement negation receiver: negates an LSB-first framed bit
// stream on the fly and presents each completed word on a registered parallel port.
module serial_neg_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x,
  input  logic             x_valid,
  input  logic             x_sof,
  output logic [WIDTH-1:0] z,
  output logic             z_valid,
  output logic             ovf,
  output logic             frame_err
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_POS = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COPY   = 2'd1,
    INVERT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             z_valid_q, z_valid_d;
  logic             ovf_q, ovf_d;
  logic             frame_err_q, frame_err_d;

  logic             take_s;
  logic             start_s;
  logic             copy_mode_s;
  logic             bit_s;
  logic [CW-1:0]    pos_s;
  logic [WIDTH-1:0] shifted_s;

  // Next-state logic: framing decisions, per-bit negation rule and word assembly.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    z_d         = z_q;
    z_valid_d   = 1'b0;
    ovf_d       = 1'b0;
    frame_err_d = 1'b0;
    take_s      = 1'b0;
    start_s     = 1'b0;

    case (state_q)
      IDLE: begin
        if (x_valid && x_sof) begin
          take_s  = 1'b1;
          start_s = 1'b1;
        end else if (x_valid) begin
          frame_err_d = 1'b1;
        end else begin
          take_s = 1'b0;
        end
      end
      COPY, INVERT: begin
        if (x_valid) begin
          take_s = 1'b1;
          // A start strobe mid-word drops the partial word and restarts at bit 0.
          if (x_sof) begin
            start_s     = 1'b1;
            frame_err_d = 1'b1;
          end else begin
            start_s = 1'b0;
          end
        end else begin
          take_s = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CW{1'b0}};
        sr_d    = {WIDTH{1'b0}};
      end
    endcase

    copy_mode_s = start_s | (state_q == COPY);
    pos_s       = start_s ? {CW{1'b0}} : cnt_q;
    bit_s       = copy_mode_s ? x : ~x;
    shifted_s   = {bit_s, sr_q[WIDTH-1:1]};

    if (take_s && (pos_s == LAST_POS)) begin
      z_d       = shifted_s;
      z_valid_d = 1'b1;
      // Still copying at the MSB means every lower bit was 0: the most-negative value.
      ovf_d     = copy_mode_s & x;
      state_d   = IDLE;
      cnt_d     = {CW{1'b0}};
      sr_d      = {WIDTH{1'b0}};
    end else if (take_s) begin
      sr_d    = shifted_s;
      cnt_d   = pos_s + CW'(1);
      state_d = (copy_mode_s && !x) ? COPY : INVERT;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= {CW{1'b0}};
      sr_q        <= {WIDTH{1'b0}};
      z_q         <= {WIDTH{1'b0}};
      z_valid_q   <= 1'b0;
      ovf_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      z_q         <= z_d;
      z_valid_q   <= z_valid_d;
      ovf_q       <= ovf_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign z         = z_q;
  assign z_valid   = z_valid_q;
  assign ovf       = ovf_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_neg_deserializer.sv
// Bench for serial_neg_deserializer: word-level negation model, per-cycle compare,
// directed scenarios with literal expectations, then randomized framed traffic.
module tb_serial_neg_deserializer;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         x;
  logic         x_valid;
  logic         x_sof;
  logic [W-1:0] z;
  logic         z_valid;
  logic         ovf;
  logic         frame_err;

  serial_neg_deserializer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .x        (x),
    .x_valid  (x_valid),
    .x_sof    (x_sof),
    .z        (z),
    .z_valid  (z_valid),
    .ovf      (ovf),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit cmp_en   = 1'b0;
  int zv_cycles[$];
  int b0c;

  // Word-level model: collects raw input bits, negates arithmetically on completion.
  bit           in_word;
  logic [W-1:0] word;
  int           nb;
  logic [W-1:0] exp_z;
  logic         exp_zv, exp_ovf, exp_fe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  task model_reset();
    in_word = 1'b0; word = '0; nb = 0;
    exp_z = '0; exp_zv = 1'b0; exp_ovf = 1'b0; exp_fe = 1'b0;
  endtask

  task model_step(input logic v, input logic s, input logic b);
    exp_zv = 1'b0; exp_ovf = 1'b0; exp_fe = 1'b0;
    if (v) begin
      if (!in_word && !s) begin
        exp_fe = 1'b1;
      end else begin
        if (s) begin
          if (in_word) exp_fe = 1'b1;
          in_word = 1'b1; word = '0; nb = 0;
        end
        word[nb] = b;
        nb++;
        if (nb == W) begin
          exp_z   = ~word + 8'd1;
          exp_zv  = 1'b1;
          exp_ovf = (word == 8'h80);
          in_word = 1'b0;
        end
      end
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("z", 32'(z), 32'(exp_z));
      chk("z_valid", 32'(z_valid), 32'(exp_zv));
      chk("ovf", 32'(ovf), 32'(exp_ovf));
      chk("frame_err", 32'(frame_err), 32'(exp_fe));
      if (z_valid) zv_cycles.push_back(cyc);
    end
  end

  task drive(input logic v, input logic s, input logic b);
    x_valid = v; x_sof = s; x = b;
    @(posedge clk);
    model_step(v, s, b);
    @(negedge clk);
  endtask

  task send_word(input logic [W-1:0] w, input int gap_at, input int gap_len);
    for (int i = 0; i < W; i++) begin
      drive(1'b1, (i == 0), w[i]);
      if (i == 0) b0c = cyc;
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      end
    end
  endtask

  int n0;
  logic [W-1:0] rw;

  initial begin
    rst_n = 1'b0; x = 1'b0; x_valid = 1'b0; x_sof = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_z", 32'(z), 32'h0);
    chk("rst_z_valid", 32'(z_valid), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    @(negedge clk);
    cmp_en = 1'b1;

    // 0xFB negates to 0x05
    send_word(8'hFB, -1, 0);
    chk("fb_z", 32'(z), 32'h05);
    chk("fb_zv", 32'(z_valid), 32'h1);
    chk("fb_ovf", 32'(ovf), 32'h0);
    drive(1'b0, 1'b0, 1'b0);

    // 0x00 then 0x80 back to back
    n0 = zv_cycles.size();
    send_word(8'h00, -1, 0);
    chk("zero_z", 32'(z), 32'h00);
    chk("zero_ovf", 32'(ovf), 32'h0);
    send_word(8'h80, -1, 0);
    chk("min_z", 32'(z), 32'h80);
    chk("min_ovf", 32'(ovf), 32'h1);
    drive(1'b0, 1'b0, 1'b0);
    chk("b2b_count", 32'(zv_cycles.size()), 32'(n0 + 2));
    if (zv_cycles.size() >= 2)
      chk("b2b_spacing", 32'(zv_cycles[$] - zv_cycles[$-1]), 32'd8);

    // 0x06 with a three-cycle gap after bit 2: bit 7 lands 10 edges after bit 0
    send_word(8'h06, 2, 3);
    chk("gap_z", 32'(z), 32'hFA);
    drive(1'b0, 1'b0, 1'b0);
    chk("gap_latency", 32'(zv_cycles[$] - b0c), 32'd10);

    // Abort 0x33 after 4 bits, restart with 0x01
    n0 = zv_cycles.size();
    for (int i = 0; i < 4; i++) drive(1'b1, (i == 0), 1'(8'h33 >> i));
    drive(1'b1, 1'b1, 1'b1);
    chk("abort_fe", 32'(frame_err), 32'h1);
    for (int i = 1; i < W; i++) drive(1'b1, 1'b0, 1'b0);
    chk("abort_z", 32'(z), 32'hFF);
    drive(1'b0, 1'b0, 1'b0);
    chk("abort_count", 32'(zv_cycles.size()), 32'(n0 + 1));

    // Stray bit while idle, then 0x02
    drive(1'b1, 1'b0, 1'b1);
    chk("idle_fe", 32'(frame_err), 32'h1);
    send_word(8'h02, -1, 0);
    chk("idle_z", 32'(z), 32'hFE);
    drive(1'b0, 1'b0, 1'b0);

    // Asynchronous reset after 5 bits, then 0x7F
    for (int i = 0; i < 5; i++) drive(1'b1, (i == 0), 1'(8'h5A >> i));
    x_valid = 1'b0; x_sof = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_z", 32'(z), 32'h0);
    chk("arst_zv", 32'(z_valid), 32'h0);
    chk("arst_ovf", 32'(ovf), 32'h0);
    chk("arst_fe", 32'(frame_err), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    n0 = zv_cycles.size();
    send_word(8'h7F, -1, 0);
    chk("post_rst_z", 32'(z), 32'h81);
    drive(1'b0, 1'b0, 1'b0);
    chk("post_rst_count", 32'(zv_cycles.size()), 32'(n0 + 1));

    // Randomized framed traffic with gaps, aborts and stray bits
    for (int k = 0; k < 600; k++) begin
      logic v, s;
      v = ($urandom_range(0, 3) != 0);
      s = in_word ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 7) != 0);
      drive(v, s, 1'($urandom_range(0, 1)));
    end
    for (int k = 0; k < 20; k++) begin
      rw = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom);
      send_word(rw, $urandom_range(0, 7), $urandom_range(0, 2));
    end
    drive(1'b0, 1'b0, 1'b0);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
